fetch_line_buffer_unit: RTL and testbench
=========================================

// Module: fetch_line_buffer_unit
// PURPOSE
// - Instruction-side memory sub-unit: the responder end of fetch's sub-unit request/response protocol.
// - Serves in-order 32-bit fetch reads from a single-line buffer.
// - Refills that buffer over a read-only burst memory port on a miss.
// - Sits beside the local-mem, icache and wishbone sub-units and is selected by fetch's address-range match.
// PARAMETERS
// - LINE_WORDS  8  words per line; power of 2, >=2.
// - LINE_W      $clog2(LINE_WORDS)  word-offset width (derived).
// PORTS
// - clk              in   1   clock
// - rst              in   1   reset; one clock; reset is asynchronous and active-high
// - new_request      in   1   fetch request; only legal while ready=1
// - addr             in   32  word address of request; addr[1:0] ignored
// - ready            out  1   request can be accepted this cycle
// - data_valid       out  1   one-cycle pulse; data_out holds a response
// - data_out         out  32  instruction word
// - invalidate       in   1   one-cycle pulse; drop buffered line (ifence)
// - mem_request      out  1   burst read request; held until mem_ack
// - mem_addr         out  32  line-aligned burst address; low LINE_W+2 bits are 0
// - mem_ack          in   1   burst request accepted
// - mem_rvalid       in   1   read beat valid
// - mem_rdata        in   32  read beat data, ascending word order
// BEHAVIOUR
// - Reset (async, while rst=1): state=IDLE, line_valid=0, tag=0, ready=0, data_valid=0, data_out=0, mem_request=0, beat count=0.
// - After reset: ready=1 in the first cycle with rst=0.
// - Accept: new_request & ready.
// - Hit test is combinational at accept: line_valid & (addr[31:LINE_W+2]==tag).
// - Hit: data_out <= line[addr[LINE_W+1:2]]; data_valid=1 the next cycle. Latency 1.
// - Hit throughput: ready stays 1, so back-to-back hits produce back-to-back data_valid.
// - Miss: IDLE->REQ; register word offset; ready=0 from the next cycle until the response cycle has completed.
// - REQ: mem_request=1 and mem_addr={addr[31:LINE_W+2],0} held stable until mem_ack. On mem_ack -> FILL.
// - FILL: each mem_rvalid writes line[beat] and increments beat (LINE_W bits).
//   - mem_rvalid is never sampled in REQ; the earliest beat is the cycle after mem_ack.
//   - On the last beat (beat==LINE_WORDS-1): tag updated; line_valid=1; beat wraps to 0; -> RESP.
// - RESP: data_out=line[saved offset]; data_valid=1 for exactly one cycle; -> IDLE; ready=1 the following cycle.
// - Ordering: at most one response per accepted request, in acceptance order.
//   - A hit accepted at N responds at N+1.
//   - A miss accepted at N+1 then responds after its fill, so ordering is preserved.
// - Outstanding: at most 2 (one hit in its response cycle + one miss accepted).
// - invalidate: line_valid <= 0 at the next edge; ready=0 during the invalidate cycle.
//   - Mid-FILL/REQ: the burst completes and the response is returned, but line_valid stays 0 afterwards (the sticky invalidate is cleared on RESP).
// - Flush: fetch discards stale responses via its own counter.
//   - This block never cancels; it always completes every accepted request.
// - Illegal: new_request while ready=0 is ignored (assertion).
// - rst mid-burst: all state cleared immediately; the memory side must also be reset by the same rst.
// STRUCTURE
// - Package cva5_types: typedef enum logic[1:0] {LB_IDLE, LB_REQ, LB_FILL, LB_RESP} line_buffer_state_t.
// - Package cva5_config: LINE_WORDS default constant.
// - No sub-module: line storage is a LINE_WORDS x 32 register array (LUTRAM-inferable, 1W/1R).
// - FSM, tag compare and beat counter are all in this file.
// TESTING
// - Cold fetch 0x1004, LINE_WORDS=8:
//   - mem_request with mem_addr=0x1000 until ack; 8 beats 0xA0..0xA7.
//   - data_valid once with data_out=0xA1; ready returns 1.
// - Then fetch 0x1000, 0x1008, 0x101C on consecutive cycles: data_valid on 3 consecutive cycles with 0xA0, 0xA2, 0xA7; no mem_request.
// - Hit 0x1010 then miss 0x2000 back-to-back: 0xA4 next cycle; ready=0; one burst at 0x2000; then the 0x2000 response.
// - invalidate pulse in FILL (beat 3): response still delivered; the following 0x1000 access is a miss (new burst).
// - rst asserted in FILL beat 5: outputs 0 asynchronously; after release ready=1, and the next request misses.
// - mem_ack delayed 10 cycles: mem_request and mem_addr held stable throughout; no beat counted before ack.

Source files
------------

// File: rtl/fetch_line_buffer_unit_pkg.sv
// rtl/fetch_line_buffer_unit_pkg.sv - shared types and defaults for the fetch line buffer
package fetch_line_buffer_unit_pkg;

    localparam int LINE_WORDS_DEFAULT = 8;

    typedef enum logic [1:0] {LB_IDLE, LB_REQ, LB_FILL, LB_RESP} line_buffer_state_t;

endpackage

// File: rtl/fetch_line_buffer_unit_if.sv
// rtl/fetch_line_buffer_unit_if.sv - fetch sub-unit request/response bundle
interface fetch_line_buffer_unit_if;
    import fetch_line_buffer_unit_pkg::*;

    logic        new_request;
    logic [31:0] addr;
    logic        ready;
    logic        data_valid;
    logic [31:0] data_out;
    logic        invalidate;

    modport master (output new_request, addr, invalidate, input ready, data_valid, data_out);
    modport slave  (input new_request, addr, invalidate, output ready, data_valid, data_out);

endinterface

// File: rtl/fetch_line_buffer_unit.sv
// rtl/fetch_line_buffer_unit.sv - single-line fetch buffer with burst refill on miss
module fetch_line_buffer_unit
    import fetch_line_buffer_unit_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_line_buffer_unit_if.slave   fetch,
    output logic                      mem_request,
    output logic [31:0]               mem_addr,
    input  logic                      mem_ack,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata
);
    localparam int LINE_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - LINE_W - 2;

    line_buffer_state_t state, next_state;

    logic              line_valid;
    logic              inval_pending;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  miss_tag;
    logic [LINE_W-1:0] offset;
    logic [LINE_W-1:0] beat;
    logic [31:0]       line [LINE_WORDS];
    logic [31:0]       data_out_r;
    logic              data_valid_r;

    logic              accept;
    logic              hit;
    logic              fill_beat;
    logic              last_beat;
    logic [TAG_W-1:0]  req_tag;
    logic [LINE_W-1:0] req_offset;
    logic              unused_addr_bits;

    assign req_tag          = fetch.addr[31:LINE_W+2];
    assign req_offset       = fetch.addr[LINE_W+1:2];
    assign unused_addr_bits = ^fetch.addr[1:0];

    // rst gates ready so it reads 0 for the whole reset, not just after the first edge
    assign fetch.ready      = (state == LB_IDLE) && !fetch.invalidate && !rst;
    assign accept           = fetch.new_request && fetch.ready;
    assign hit              = line_valid && (req_tag == tag);
    assign fill_beat        = (state == LB_FILL) && mem_rvalid;
    assign last_beat        = fill_beat && (beat == LINE_W'(LINE_WORDS - 1));

    assign mem_request      = (state == LB_REQ);
    assign mem_addr         = {miss_tag, {(LINE_W + 2){1'b0}}};
    assign fetch.data_valid = data_valid_r;
    assign fetch.data_out   = data_out_r;

    always_comb begin
        next_state = state;
        case (state)
            LB_IDLE: if (accept && !hit) next_state = LB_REQ;
            LB_REQ:  if (mem_ack)        next_state = LB_FILL;
            LB_FILL: if (last_beat)      next_state = LB_RESP;
            LB_RESP:                     next_state = LB_IDLE;
            default:                     next_state = LB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LB_IDLE;
            line_valid    <= 1'b0;
            inval_pending <= 1'b0;
            tag           <= '0;
            miss_tag      <= '0;
            offset        <= '0;
            beat          <= '0;
            data_valid_r  <= 1'b0;
            data_out_r    <= '0;
        end else begin
            state        <= next_state;
            data_valid_r <= 1'b0;

            if (accept) begin
                if (hit) begin
                    data_valid_r <= 1'b1;
                    data_out_r   <= line[req_offset];
                end else begin
                    miss_tag <= req_tag;
                    offset   <= req_offset;
                end
            end

            if (fill_beat)
                beat <= beat + 1'b1;

            // The requested word may be the beat arriving right now, so forward it
            if (last_beat) begin
                tag          <= miss_tag;
                data_valid_r <= 1'b1;
                data_out_r   <= (offset == beat) ? mem_rdata : line[offset];
            end

            if (fetch.invalidate && (state == LB_REQ || state == LB_FILL))
                inval_pending <= 1'b1;
            else if (state == LB_RESP)
                inval_pending <= 1'b0;

            if (fetch.invalidate)
                line_valid <= 1'b0;
            else if (last_beat)
                line_valid <= !inval_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_beat)
            line[beat] <= mem_rdata;
    end

    assert property (@(posedge clk) disable iff (rst) !(fetch.new_request && !fetch.ready));

endmodule

// File: tb/tb_fetch_line_buffer_unit.sv
// tb/tb_fetch_line_buffer_unit.sv - randomized self-checking bench for fetch_line_buffer_unit
module tb_fetch_line_buffer_unit;
    import fetch_line_buffer_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    fetch_line_buffer_unit_if bus ();

    fetch_line_buffer_unit #(.LINE_WORDS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (bus.slave),
        .mem_request (mem_request),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          is_hit;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] burst_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bursts = 0;
    int          model_bursts = 0;
    bit          model_valid = 0;
    logic [26:0] model_tag = '0;
    int          ack_delay = 0;
    bit          junk_en = 0;
    int          rs_phase = 0;
    int          beats_sent = 0;
    int          wait_cnt = 0;
    logic [31:0] rs_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory: line 0x1000 holds 0xA0..0xA7, everything else is address-derived
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h80)
            return 32'hA0 + 32'(a[4:2]);
        return a ^ 32'h5EED_0000;
    endfunction

    initial begin
        mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
            if (rst) begin
                rs_phase = 0;
                beats_sent = 0;
            end else begin
                if (rs_phase == 0 && mem_request) begin
                    rs_phase = 1;
                    wait_cnt = ack_delay;
                    rs_addr  = mem_addr;
                    if (burst_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL burst_unexpected got %h expected none", mem_addr);
                    end else begin
                        check_eq("burst_addr", mem_addr, burst_q.pop_front());
                    end
                end else if (rs_phase == 1) begin
                    check_eq("req_hold", 32'(mem_request), 32'd1);
                    check_eq("addr_hold", mem_addr, rs_addr);
                end
                if (rs_phase == 1) begin
                    if (wait_cnt == 0) begin
                        mem_ack = 1; rs_phase = 2; bursts++;
                    end else begin
                        wait_cnt--;
                    end
                    if (junk_en) begin mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; end
                end else if (rs_phase == 2) begin
                    if ($urandom_range(0, 3) != 0) begin
                        mem_rvalid = 1;
                        mem_rdata  = mem_word(rs_addr + 32'(beats_sent * 4));
                        beats_sent++;
                        if (beats_sent == 8) begin beats_sent = 0; rs_phase = 0; end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_resp got %h expected none", bus.data_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("resp_data", bus.data_out, e.data);
                    if (e.is_hit) check_eq("hit_latency", 32'(cyc), 32'(e.acc + 1));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        int b;
        bit h;
        exp_t e;
        b = 0;
        @(negedge clk);
        while (!bus.ready && b < 400) begin
            bus.new_request = 0;
            @(negedge clk);
            b++;
        end
        if (!bus.ready) begin
            check_eq("ready_timeout", 32'(bus.ready), 32'd1);
            bus.new_request = 0;
            return;
        end
        h = model_valid && (model_tag == a[31:5]);
        if (!h) begin
            model_tag   = a[31:5];
            model_valid = 1;
            burst_q.push_back({a[31:5], 5'b0});
            model_bursts++;
        end
        e.data   = mem_word({a[31:2], 2'b00});
        e.is_hit = h;
        e.acc    = cyc;
        exp_q.push_back(e);
        bus.addr        = a;
        bus.new_request = 1;
        @(posedge clk);
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.new_request = 0;
    endtask

    task automatic do_inval();
        @(negedge clk);
        bus.new_request = 0;
        bus.invalidate  = 1;
        model_valid     = 0;
        @(negedge clk);
        bus.invalidate  = 0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        @(negedge clk);
        bus.new_request = 0;
        while ((exp_q.size() != 0 || !bus.ready) && b < 500) begin
            @(negedge clk);
            b++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        check_eq("burst_count", 32'(bursts), 32'(model_bursts));
    endtask

    task automatic wait_beats(input int n);
        int b;
        b = 0;
        while (!(rs_phase == 2 && beats_sent >= n) && b < 200) begin
            @(posedge clk);
            b++;
        end
        check_eq("beat_wait", 32'(beats_sent >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.new_request = 0;
        bus.addr        = 0;
        bus.invalidate  = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_dvalid", 32'(bus.data_valid), 32'd0);
        check_eq("rst_dout", bus.data_out, 32'd0);
        check_eq("rst_mreq", 32'(mem_request), 32'd0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        rst = 0;
        #1;
        check_eq("ready_after_rst", 32'(bus.ready), 32'd1);

        issue(32'h1004);
        wait_drain();
        check_eq("cold_dout", bus.data_out, 32'hA1);

        issue(32'h1000);
        issue(32'h1008);
        issue(32'h101C);
        wait_drain();

        issue(32'h1010);
        issue(32'h2000);
        release_req();
        check_eq("miss_stall", 32'(bus.ready), 32'd0);
        wait_drain();

        issue(32'h1000);
        release_req();
        wait_beats(3);
        do_inval();
        wait_drain();
        issue(32'h1000);
        wait_drain();

        issue(32'h3000);
        release_req();
        wait_beats(5);
        #2 rst = 1;
        #1;
        check_eq("arst_ready", 32'(bus.ready), 32'd0);
        check_eq("arst_dvalid", 32'(bus.data_valid), 32'd0);
        check_eq("arst_dout", bus.data_out, 32'd0);
        check_eq("arst_mreq", 32'(mem_request), 32'd0);
        exp_q.delete();
        burst_q.delete();
        model_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check_eq("ready_after_arst", 32'(bus.ready), 32'd1);
        issue(32'h1000);
        wait_drain();

        ack_delay = 10;
        junk_en   = 1;
        issue(32'h4008);
        wait_drain();
        ack_delay = 0;
        junk_en   = 0;

        for (int i = 0; i < 200; i++) begin
            int r;
            logic [31:0] base;
            r = $urandom_range(0, 3);
            base = (r == 0) ? 32'h1000 : (r == 1) ? 32'h2000 : (r == 2) ? 32'h3000 : 32'h5000;
            issue(base + 32'($urandom_range(0, 7) * 4));
            ack_delay = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 3) release_req();
            if (r == 0) do_inval();
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
